// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Buffers a short program of 16-bit instructions written by a host and then
//   issues them in order, holding each word for HOLD_CYCLES clocks.
//
//   Ports
//     clk          clock, all state on posedge
//     reset        synchronous reset, active-low
//     load_en      append load_data to the buffer (IDLE only)
//     load_data    instruction word to append
//     load_ready   a load_en this cycle would be accepted
//     clear        empty the buffer and clear overflow (IDLE only)
//     start        begin issuing buffer[0..count-1]
//     abort        stop issuing, return to IDLE
//     instruction  word presented to the processor
//     instr_valid  instruction is a real program word
//     busy         high while issuing
//     done         one-cycle pulse after the last hold completes
//     overflow     sticky, load_en seen while full
//     count        number of words loaded
//     pc           index of the word being issued
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | accept loads / clear / start
//   RUN   | presenting prog_mem[pc], hold timer counting
//   DONE  | one-cycle done pulse, then back to IDLE
module instruction_sequencer #(
  parameter int          DEPTH       = 16,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [15:0] IDLE_INSTR  = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [15:0]              load_data,
  output logic                     load_ready,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     abort,
  output logic [15:0]              instruction,
  output logic                     instr_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [15:0]   prog_mem [DEPTH];
  logic [HW-1:0] hold, hold_nxt;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] pc_nxt;
  logic          overflow_nxt;
  logic          wr_en;
  logic [15:0]   instruction_nxt;
  logic          instr_valid_nxt, busy_nxt, done_nxt, load_ready_nxt;

  logic hold_zero, last_word, start_ok;
  assign hold_zero = (hold == '0);
  assign last_word = (CW'(pc) == count - CW'(1));
  assign start_ok  = start && (count != '0);

  // State and all output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= '0;
      pc          <= '0;
      hold        <= '0;
      overflow    <= 1'b0;
      instruction <= IDLE_INSTR;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      pc          <= pc_nxt;
      hold        <= hold_nxt;
      overflow    <= overflow_nxt;
      instruction <= instruction_nxt;
      instr_valid <= instr_valid_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      load_ready  <= load_ready_nxt;
    end
  end

  // Buffer contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (wr_en) prog_mem[count[PW-1:0]] <= load_data;
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_RUN;
      S_RUN: begin
        if (abort)                       state_nxt = S_IDLE;
        else if (hold_zero && last_word) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values and registered-output next values
  always_comb begin
    count_nxt    = count;
    pc_nxt       = pc;
    hold_nxt     = hold;
    overflow_nxt = overflow;
    wr_en        = 1'b0;
    case (state)
      S_IDLE: begin
        // start beats clear, and clear beats load_en
        if (start_ok) begin
          pc_nxt   = '0;
          hold_nxt = HOLD_LOAD;
        end else if (clear) begin
          count_nxt    = '0;
          overflow_nxt = 1'b0;
        end else if (load_en) begin
          if (count < FULL) begin
            wr_en     = 1'b1;
            count_nxt = count + CW'(1);
          end else begin
            overflow_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          pc_nxt   = '0;
          hold_nxt = '0;
        end else if (hold_zero) begin
          if (!last_word) begin
            pc_nxt   = pc + PW'(1);
            hold_nxt = HOLD_LOAD;
          end
        end else begin
          hold_nxt = hold - HW'(1);
        end
      end
      S_DONE: begin
        pc_nxt   = '0;
        hold_nxt = '0;
      end
      default: begin
        pc_nxt   = '0;
        hold_nxt = '0;
      end
    endcase

    instr_valid_nxt = (state_nxt == S_RUN);
    busy_nxt        = (state_nxt == S_RUN);
    done_nxt        = (state_nxt == S_DONE);
    instruction_nxt = (state_nxt == S_RUN) ? prog_mem[pc_nxt] : IDLE_INSTR;
    load_ready_nxt  = (state_nxt == S_IDLE) && (count_nxt < FULL);
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer
//   Directed bench: main instance uses DEPTH=16, HOLD_CYCLES=4; a second
//   instance with HOLD_CYCLES=1 covers back-to-back single-cycle issue.
module tb_instruction_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load_en, clear, start, abort;
  logic [15:0] load_data;
  logic        load_ready, instr_valid, busy, done, overflow;
  logic [15:0] instruction;
  logic [4:0]  count;
  logic [3:0]  pc;

  logic        l2_en, c2, s2, a2;
  logic [15:0] l2_data;
  logic        i2_ready, i2_valid, i2_busy, i2_done, i2_ovf;
  logic [15:0] i2_instr;
  logic [4:0]  i2_count;
  logic [3:0]  i2_pc;

  int checks = 0;
  int passed = 0;

  instruction_sequencer #(.DEPTH(16), .HOLD_CYCLES(4), .IDLE_INSTR(16'h0000)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
    .load_ready(load_ready), .clear(clear), .start(start), .abort(abort),
    .instruction(instruction), .instr_valid(instr_valid), .busy(busy),
    .done(done), .overflow(overflow), .count(count), .pc(pc)
  );

  instruction_sequencer #(.DEPTH(16), .HOLD_CYCLES(1), .IDLE_INSTR(16'h0000)) dut_h1 (
    .clk(clk), .reset(reset), .load_en(l2_en), .load_data(l2_data),
    .load_ready(i2_ready), .clear(c2), .start(s2), .abort(a2),
    .instruction(i2_instr), .instr_valid(i2_valid), .busy(i2_busy),
    .done(i2_done), .overflow(i2_ovf), .count(i2_count), .pc(i2_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    load_en = 1'b1; load_data = w;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    checks++;
    if ({instr_valid, busy, done, overflow, load_ready} !== 5'b00001)
      $display("FAIL reset_flags got v,b,d,o,r=%b exp 00001",
               {instr_valid, busy, done, overflow, load_ready});
    else passed++;
    checks++;
    if (instruction !== 16'h0000 || count !== 5'd0 || pc !== 4'd0)
      $display("FAIL reset_values got instr=%h count=%0d pc=%0d exp 0000/0/0", instruction, count, pc);
    else passed++;
    checks++;
    if ({i2_valid, i2_busy, i2_done, i2_ovf, i2_ready} !== 5'b00001 || i2_count !== 5'd0)
      $display("FAIL reset_h1 got flags=%b count=%0d exp 00001/0",
               {i2_valid, i2_busy, i2_done, i2_ovf, i2_ready}, i2_count);
    else passed++;
  endtask

  task automatic test_basic_run();
    logic [15:0] prog [3];
    prog[0] = 16'h0005; prog[1] = 16'h4205; prog[2] = 16'h8000;
    for (int i = 0; i < 3; i++) load_word(prog[i]);
    checks++;
    if (count !== 5'd3) $display("FAIL t1_count_loaded got %0d exp 3", count);
    else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({instr_valid, busy, done} !== 3'b110 || instruction !== prog[i/4] || pc !== 4'(i/4))
        $display("FAIL t1_issue cyc=%0d got v,b,d=%b instr=%h pc=%0d exp 110 instr=%h pc=%0d",
                 i, {instr_valid, busy, done}, instruction, pc, prog[i/4], i/4);
      else passed++;
      tick();
    end
    checks++;
    if ({instr_valid, busy, done} !== 3'b001 || instruction !== 16'h0000)
      $display("FAIL t1_done got v,b,d=%b instr=%h exp 001 instr=0000", {instr_valid, busy, done}, instruction);
    else passed++;
    tick();
    checks++;
    if (done !== 1'b0 || count !== 5'd3 || load_ready !== 1'b1)
      $display("FAIL t1_after got done=%b count=%0d ready=%b exp 0/3/1", done, count, load_ready);
    else passed++;
  endtask

  task automatic test_overflow();
    do_clear();
    checks++;
    if (count !== 5'd0) $display("FAIL t2_clear_first got %0d exp 0", count);
    else passed++;
    for (int i = 0; i < 16; i++) load_word(16'h1000 + 16'(i));
    checks++;
    if (count !== 5'd16 || load_ready !== 1'b0 || overflow !== 1'b0)
      $display("FAIL t2_full got count=%0d ready=%b ovf=%b exp 16/0/0", count, load_ready, overflow);
    else passed++;
    load_word(16'h1010);
    checks++;
    if (count !== 5'd16 || load_ready !== 1'b0 || overflow !== 1'b1)
      $display("FAIL t2_overflow got count=%0d ready=%b ovf=%b exp 16/0/1", count, load_ready, overflow);
    else passed++;
    do_clear();
    checks++;
    if (count !== 5'd0 || overflow !== 1'b0 || load_ready !== 1'b1)
      $display("FAIL t2_clear got count=%0d ovf=%b ready=%b exp 0/0/1", count, overflow, load_ready);
    else passed++;
  endtask

  task automatic test_start_edge();
    int seen_busy, seen_done;
    seen_busy = 0; seen_done = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy === 1'b1) seen_busy++;
      if (done === 1'b1) seen_done++;
      tick();
    end
    checks++;
    if (seen_busy != 0 || seen_done != 0 || count !== 5'd0)
      $display("FAIL t3_empty_start got busy_cycles=%0d done_cycles=%0d count=%0d exp 0/0/0",
               seen_busy, seen_done, count);
    else passed++;
    load_word(16'h8000);
    start = 1'b1; load_en = 1'b1; load_data = 16'hBEEF;
    tick();
    start = 1'b0; load_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({instr_valid, busy} !== 2'b11 || instruction !== 16'h8000 || count !== 5'd1 || overflow !== 1'b0)
        $display("FAIL t3_one_word cyc=%0d got v,b=%b instr=%h count=%0d ovf=%b exp 11/8000/1/0",
                 i, {instr_valid, busy}, instruction, count, overflow);
      else passed++;
      tick();
    end
    checks++;
    if (done !== 1'b1 || instr_valid !== 1'b0)
      $display("FAIL t3_one_word_done got done=%b v=%b exp 1/0", done, instr_valid);
    else passed++;
    tick();
    checks++;
    if (count !== 5'd1) $display("FAIL t3_count_kept got %0d exp 1", count);
    else passed++;
  endtask

  task automatic test_abort();
    int seen_done;
    seen_done = 0;
    do_clear();
    load_word(16'h0011); load_word(16'h4222); load_word(16'h8003);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pc !== 4'd1 || instruction !== 16'h4222)
      $display("FAIL t4_pre_abort got pc=%0d instr=%h exp 1/4222", pc, instruction);
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({instr_valid, busy, done} !== 3'b000 || pc !== 4'd0 || count !== 5'd3 || instruction !== 16'h0000)
      $display("FAIL t4_abort got v,b,d=%b pc=%0d count=%0d instr=%h exp 000/0/3/0000",
               {instr_valid, busy, done}, pc, count, instruction);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) seen_done++;
      tick();
    end
    checks++;
    if (seen_done != 0) $display("FAIL t4_no_done got done_cycles=%0d exp 0", seen_done);
    else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (instruction !== 16'h0011 || pc !== 4'd0 || instr_valid !== 1'b1)
      $display("FAIL t4_replay got instr=%h pc=%0d v=%b exp 0011/0/1", instruction, pc, instr_valid);
    else passed++;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (done !== 1'b1) $display("FAIL t4_replay_done got %b exp 1", done);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (pc !== 4'd2 || instruction !== 16'h8003)
      $display("FAIL t5_pre_reset got pc=%0d instr=%h exp 2/8003", pc, instruction);
    else passed++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({instr_valid, busy, done, overflow, load_ready} !== 5'b00001 ||
        instruction !== 16'h0000 || count !== 5'd0 || pc !== 4'd0)
      $display("FAIL t5_reset got flags=%b instr=%h count=%0d pc=%0d exp 00001/0000/0/0",
               {instr_valid, busy, done, overflow, load_ready}, instruction, count, pc);
    else passed++;
  endtask

  task automatic test_ignored_in_run();
    do_clear();
    load_word(16'h0101); load_word(16'h4102); load_word(16'h8103);
    start = 1'b1;
    tick();
    load_en = 1'b1; load_data = 16'hFFFF; clear = 1'b1;
    tick(); tick();
    load_en = 1'b0; clear = 1'b0; start = 1'b0;
    checks++;
    if (count !== 5'd3 || overflow !== 1'b0 || load_ready !== 1'b0 ||
        instruction !== 16'h0101 || pc !== 4'd0 || instr_valid !== 1'b1)
      $display("FAIL t6_ignored got count=%0d ovf=%b ready=%b instr=%h pc=%0d v=%b exp 3/0/0/0101/0/1",
               count, overflow, load_ready, instruction, pc, instr_valid);
    else passed++;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (done !== 1'b1 || count !== 5'd3)
      $display("FAIL t6_done got done=%b count=%0d exp 1/3", done, count);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [4];
    prog[0] = 16'h0A01; prog[1] = 16'h4A02; prog[2] = 16'h8A03; prog[3] = 16'hCA04;
    for (int i = 0; i < 4; i++) begin
      l2_en = 1'b1; l2_data = prog[i];
      tick();
    end
    l2_en = 1'b0;
    s2 = 1'b1;
    tick();
    s2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({i2_valid, i2_busy, i2_done} !== 3'b110 || i2_instr !== prog[i] || i2_pc !== 4'(i))
        $display("FAIL t6_h1_issue cyc=%0d got v,b,d=%b instr=%h pc=%0d exp 110 instr=%h pc=%0d",
                 i, {i2_valid, i2_busy, i2_done}, i2_instr, i2_pc, prog[i], i);
      else passed++;
      tick();
    end
    checks++;
    if ({i2_valid, i2_busy, i2_done} !== 3'b001 || i2_count !== 5'd4)
      $display("FAIL t6_h1_done got v,b,d=%b count=%0d exp 001/4", {i2_valid, i2_busy, i2_done}, i2_count);
    else passed++;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    load_en = 1'b0; clear = 1'b0; start = 1'b0; abort = 1'b0; load_data = 16'h0000;
    l2_en = 1'b0; c2 = 1'b0; s2 = 1'b0; a2 = 1'b0; l2_data = 16'h0000;
    #2;
    test_reset();
    test_basic_run();
    test_overflow();
    test_start_edge();
    test_abort();
    test_reset_mid_run();
    test_ignored_in_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
